// File: rtl/hex_scroll_ctrl.sv
// Scrolling hex display sequencer: accepts nibbles over valid/ready, shifts them
// right-to-left on a programmable tick, with clear and whole-display blink.

module hex_scroll_digit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] val,
  input  logic       vld,
  input  logic       blank,
  output logic [6:0] seg
);
  logic [6:0] seg_d, seg_q;

  always_comb begin
    seg_d = 7'h7F;
    if (vld && !blank) begin
      unique case (val)
        4'h0: seg_d = 7'h40;
        4'h1: seg_d = 7'h4F;
        4'h2: seg_d = 7'h24;
        4'h3: seg_d = 7'h30;
        4'h4: seg_d = 7'h19;
        4'h5: seg_d = 7'h12;
        4'h6: seg_d = 7'h02;
        4'h7: seg_d = 7'h78;
        4'h8: seg_d = 7'h00;
        4'h9: seg_d = 7'h18;
        4'hA: seg_d = 7'h08;
        4'hB: seg_d = 7'h03;
        4'hC: seg_d = 7'h46;
        4'hD: seg_d = 7'h21;
        4'hE: seg_d = 7'h06;
        default: seg_d = 7'h0E;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seg_q <= 7'h7F;
    else        seg_q <= seg_d;
  end

  assign seg = seg_q;
endmodule

module hex_scroll_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int SCROLL_DIV = 12_500_000,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [3:0]              in_data,
  output logic                    in_ready,
  input  logic                    clear,
  input  logic                    blink_en,
  output logic                    busy,
  output logic [7*NUM_DIGITS-1:0] seg
);
  localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCROLL_LAST = SW'(SCROLL_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_DIV - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e                         state_d, state_q;
  logic [3:0]                     pend_d, pend_q;
  logic [NUM_DIGITS-1:0][3:0]     dig_d, dig_q;
  logic [NUM_DIGITS-1:0]          dv_d, dv_q;
  logic [SW-1:0]                  scnt_d, scnt_q;
  logic [BW-1:0]                  bcnt_d, bcnt_q;
  logic                           phase_d, phase_q;
  logic                           tick;
  logic                           blank;

  assign tick     = (scnt_q == SCROLL_LAST);
  assign in_ready = (state_q == S_IDLE) && !clear;
  assign busy     = (state_q == S_WAIT);
  // Gate with blink_en so dropping it steadies the display on the next seg update.
  assign blank    = blink_en && phase_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    dig_d   = dig_q;
    dv_d    = dv_q;
    phase_d = phase_q;
    scnt_d  = tick ? '0 : scnt_q + SW'(1);
    bcnt_d  = '0;

    if (blink_en) begin
      if (bcnt_q == BLINK_LAST) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end else begin
      phase_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          pend_d  = in_data;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tick) begin
          for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            dig_d[i] = dig_q[i-1];
            dv_d[i]  = dv_q[i-1];
          end
          dig_d[0] = pend_q;
          dv_d[0]  = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Clear overrides everything, including a shift landing on the same tick.
    if (clear) begin
      state_d = S_IDLE;
      dv_d    = '0;
      scnt_d  = '0;
      bcnt_d  = '0;
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      dig_q   <= '0;
      dv_q    <= '0;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      dig_q   <= dig_d;
      dv_q    <= dv_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    hex_scroll_digit u_dig (
      .clk   (clk),
      .rst_n (rst_n),
      .val   (dig_q[g]),
      .vld   (dv_q[g]),
      .blank (blank),
      .seg   (seg[7*g +: 7])
    );
  end
endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Bench for hex_scroll_ctrl: directed sequence plus random traffic against a
// queue-based model of the visible display.

module tb_hex_scroll_ctrl;
  localparam int ND = 6;
  localparam int SD = 4;
  localparam int BD = 8;
  localparam logic [41:0] ALL_BLANK = {ND{7'h7F}};

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic [3:0]     in_data = 4'h0;
  logic           in_ready;
  logic           clear = 1'b0;
  logic           blink_en = 1'b0;
  logic           busy;
  logic [7*ND-1:0] seg;

  hex_scroll_ctrl #(.NUM_DIGITS(ND), .SCROLL_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .clear(clear), .blink_en(blink_en), .busy(busy), .seg(seg)
  );

  always #5 clk = ~clk;

  logic [6:0] enc [16] = '{7'h40, 7'h4F, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int errs = 0;
  int checks = 0;

  // Model: disp[0] is the rightmost digit; missing entries are blank.
  int unsigned disp[$];
  bit          m_wait;
  int unsigned m_pend;
  int          m_scnt, m_bcnt;
  bit          m_phase;
  logic [41:0] m_seg;
  bit          accepted;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [41:0] render(input bit blanked);
    logic [41:0] r;
    r = ALL_BLANK;
    if (!blanked)
      for (int i = 0; i < disp.size(); i++) r[7*i +: 7] = enc[disp[i]];
    return r;
  endfunction

  task automatic model_reset();
    disp.delete();
    m_wait = 0; m_pend = 0; m_scnt = 0; m_bcnt = 0; m_phase = 0;
    m_seg = ALL_BLANK;
  endtask

  task automatic model_edge();
    bit tick;
    tick = (m_scnt == SD - 1);
    accepted = 0;
    m_seg = render(blink_en && m_phase);
    if (clear) begin
      disp.delete();
      m_wait = 0; m_scnt = 0; m_bcnt = 0; m_phase = 0;
    end else begin
      m_scnt = (m_scnt + 1) % SD;
      if (blink_en) begin
        m_bcnt++;
        if (m_bcnt == BD) begin m_bcnt = 0; m_phase = !m_phase; end
      end else begin
        m_bcnt = 0; m_phase = 0;
      end
      if (!m_wait && in_valid) begin
        m_pend = in_data; m_wait = 1; accepted = 1;
      end else if (m_wait && tick) begin
        disp.push_front(m_pend);
        if (disp.size() > ND) void'(disp.pop_back());
        m_wait = 0;
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".seg"}, 64'(seg), 64'(m_seg));
    chk({tag, ".ready"}, 64'(in_ready), 64'(!m_wait && !clear));
    chk({tag, ".busy"}, 64'(busy), 64'(m_wait));
  endtask

  task automatic push(input logic [3:0] d, input string tag);
    int guard;
    in_valid = 1; in_data = d;
    guard = 0;
    do begin step(tag); guard++; end while (!accepted && guard < 50);
    in_valid = 0;
    chk({tag, ".accept_timeout"}, 64'(accepted), 64'(1));
    guard = 0;
    while (m_wait && guard < 50) begin step(tag); guard++; end
    step(tag);
  endtask

  initial begin
    int idx, guard;
    logic [3:0] seq7 [7];
    model_reset();
    #12 rst_n = 1'b1;
    #1;
    chk("reset.seg", 64'(seg), 64'(ALL_BLANK));
    chk("reset.ready", 64'(in_ready), 64'(1));
    chk("reset.busy", 64'(busy), 64'(0));
    for (int i = 0; i < 20; i++) step("idle");

    // Single push of 1
    push(4'h1, "push1");
    chk("push1.digits", 64'(seg), 64'({{5{7'h7F}}, 7'h4F}));

    // Back-to-back 0..6 with in_valid held
    for (int i = 0; i < 7; i++) seq7[i] = 4'(i);
    idx = 0; guard = 0;
    in_valid = 1; in_data = seq7[0];
    while (idx < 7 && guard < 200) begin
      step("b2b");
      guard++;
      if (accepted) begin
        idx++;
        if (idx < 7) in_data = seq7[idx];
        else in_valid = 0;
      end
    end
    in_valid = 0;
    chk("b2b.timeout", 64'(idx), 64'(7));
    guard = 0;
    while (m_wait && guard < 50) begin step("b2b_drain"); guard++; end
    step("b2b_drain");
    chk("b2b.final", 64'(seg), 64'({7'h4F, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}));

    // Push 8 then clear before the tick
    guard = 0;
    while (m_scnt != 0 && guard < 10) begin step("clr_align"); guard++; end
    in_valid = 1; in_data = 4'h8;
    step("clr_push");
    in_valid = 0;
    chk("clr.accepted", 64'(busy), 64'(1));
    clear = 1;
    step("clr_on");
    chk("clr.ready_low", 64'(in_ready), 64'(0));
    clear = 0;
    #1;
    chk("clr.ready_back", 64'(in_ready), 64'(1));
    for (int i = 0; i < 10; i++) step("clr_after");
    chk("clr.blank", 64'(seg), 64'(ALL_BLANK));

    // Blink with A and F shown
    push(4'hA, "blinkA");
    push(4'hF, "blinkF");
    chk("blink.steady", 64'(seg), 64'({{4{7'h7F}}, 7'h08, 7'h0E}));
    blink_en = 1;
    for (int i = 0; i < 40; i++) step("blink");
    guard = 0;
    while (!m_phase && guard < 20) begin step("blink_seek"); guard++; end
    step("blink_ph1");
    chk("blink.ph1_dark", 64'(seg), 64'(ALL_BLANK));
    blink_en = 0;
    step("blink_off");
    chk("blink.off_steady", 64'(seg), 64'({{4{7'h7F}}, 7'h08, 7'h0E}));
    for (int i = 0; i < 10; i++) step("blink_off");

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      in_valid = ($urandom_range(0, 1) == 1);
      in_data  = 4'($urandom);
      clear    = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 59) == 0) blink_en = !blink_en;
      step("rand");
    end
    in_valid = 0; clear = 0; blink_en = 0;

    // Async reset mid-WAIT
    in_valid = 1; in_data = 4'h3;
    guard = 0;
    do begin step("arst_push"); guard++; end while (!accepted && guard < 20);
    in_valid = 0;
    chk("arst.in_wait", 64'(busy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst.seg", 64'(seg), 64'(ALL_BLANK));
    chk("arst.busy", 64'(busy), 64'(0));
    chk("arst.ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 12; i++) step("post_arst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
